// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin arbiter and its skid buffer.
// beat_t is sized from the package defaults; the arbiter's DATA_W/N_SRC defaults track them.
package axis_arb_pkg;

    localparam int unsigned ARB_N_SRC  = 4;
    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned ARB_ID_W   = (ARB_N_SRC > 1) ? $clog2(ARB_N_SRC) : 1;
    localparam int unsigned RR_MAX_SRC = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [ARB_DATA_W-1:0]   tdata;
        logic [ARB_DATA_W/8-1:0] tkeep;
        logic                    tlast;
        logic [ARB_ID_W-1:0]     tid;
    } beat_t;

    // First requester after 'last', wrapping modulo n; returns 'last' when nothing requests.
    function automatic logic [3:0] rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                           input logic [3:0]            last,
                                           input int unsigned           n);
        logic [3:0] pick;
        logic [3:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX_SRC; i++) begin
            idx = 4'((32'(last) + i) % n);
            if (i <= n && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry FIFO-ordered registered buffer with valid/ready on both sides.
// Outputs come straight from the head register so downstream timing is isolated.
module axis_skid_buf
    import axis_arb_pkg::*;
#(
    parameter type T = beat_t
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic [1:0] count_q, count_d;
    T           head_q, head_d;
    T           tail_q, tail_d;
    logic       push;
    logic       pop;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = in_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    tail_d  = in_data;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                // Full: no push is possible, a pop promotes the second entry.
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI4-Stream arbiter: packet-granular round robin, grant held until TLAST,
// winning source reported on m_tid, output registered through a 2-entry skid buffer.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned N_SRC  = ARB_N_SRC,
    parameter int unsigned DATA_W = ARB_DATA_W,
    parameter int unsigned ID_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_SRC-1:0]          s_tvalid,
    output logic [N_SRC-1:0]          s_tready,
    input  logic [N_SRC*DATA_W-1:0]   s_tdata,
    input  logic [N_SRC*DATA_W/8-1:0] s_tkeep,
    input  logic [N_SRC-1:0]          s_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic [DATA_W/8-1:0]       m_tkeep,
    output logic                      m_tlast,
    output logic [ID_W-1:0]           m_tid,
    output logic                      busy
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic            buf_in_ready;
    logic            accept;
    beat_t           in_beat;
    beat_t           out_beat;

    assign busy   = (state_q == BUSY);
    assign accept = busy && s_tvalid[grant_q] && buf_in_ready;

    always_comb begin
        s_tready = '0;
        if (busy) begin
            s_tready[grant_q] = buf_in_ready;
        end
    end

    always_comb begin
        in_beat       = '0;
        in_beat.tdata = s_tdata[grant_q*DATA_W +: DATA_W];
        in_beat.tkeep = s_tkeep[grant_q*(DATA_W/8) +: DATA_W/8];
        in_beat.tlast = s_tlast[grant_q];
        in_beat.tid   = grant_q;
    end

    // The arbitration decision only looks at requests in IDLE, never at m_tready.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|s_tvalid) begin
                    grant_d = ID_W'(rr_pick(RR_MAX_SRC'(s_tvalid), 4'(last_grant_q), N_SRC));
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && s_tlast[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(N_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    axis_skid_buf #(
        .T(beat_t)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (busy && s_tvalid[grant_q]),
        .in_ready  (buf_in_ready),
        .in_data   (in_beat),
        .out_valid (m_tvalid),
        .out_ready (m_tready),
        .out_data  (out_beat)
    );

    assign m_tdata = out_beat.tdata;
    assign m_tkeep = out_beat.tkeep;
    assign m_tlast = out_beat.tlast;
    assign m_tid   = out_beat.tid;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: a directed vector table, hand-built corner-case sequences,
// and randomized traffic compared every cycle against a queue-based behavioural model.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int IW = 2;

    typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; int gap; } src_beat_t;
    typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; int tid; } out_beat_t;
    typedef struct {
        logic vld; logic [DW-1:0] data; logic last; logic mready;
        logic exp_mvalid; logic [DW-1:0] exp_mdata; logic exp_mlast; logic exp_ready0; logic exp_busy;
    } vector_t;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N-1:0]    s_tvalid, s_tready, s_tlast;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic            m_tvalid, m_tready, m_tlast, busy;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [IW-1:0]   m_tid;

    axis_rr_arbiter #(.N_SRC(N), .DATA_W(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    src_beat_t       src_q [N][$];
    out_beat_t       ref_buf [$];
    bit              ref_busy;
    int              ref_grant, ref_last;
    bit              presenting [N];
    int              pause [N];
    logic [N-1:0]    exp_ready;
    int              cyc;
    bit              mr_random;
    int              stall_lo, stall_hi;
    bit              bp_watch;
    int              bp_obs;
    int              total_loaded;
    int              dut_pkt_log [$];
    logic [DW-1:0]   dut_data_log [$];
    int              exp_pkt [$];
    logic [DW-1:0]   exp_data [$];
    vector_t         vec [6];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic mready);
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = presenting[i];
            if (presenting[i]) begin
                s_tdata[i*DW +: DW] = src_q[i][0].data;
                s_tkeep[i*KW +: KW] = src_q[i][0].keep;
                s_tlast[i]          = src_q[i][0].last;
            end else begin
                s_tdata[i*DW +: DW] = '0;
                s_tkeep[i*KW +: KW] = '0;
                s_tlast[i]          = 1'b0;
            end
        end
        m_tready = mready;
    endtask

    task automatic model_reset();
        ref_buf.delete();
        ref_busy     = 1'b0;
        ref_grant    = 0;
        ref_last     = N - 1;
        total_loaded = 0;
        exp_ready    = '0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            presenting[i] = 1'b0;
            pause[i]      = 0;
        end
    endtask

    task automatic load_beat(input int src, input logic [DW-1:0] data, input logic [KW-1:0] keep,
                             input logic last, input int gap);
        src_beat_t b;
        b.data = data; b.keep = keep; b.last = last; b.gap = gap;
        src_q[src].push_back(b);
        total_loaded++;
    endtask

    task automatic load_packet(input int src, input int len, input int first_gap);
        for (int b = 0; b < len; b++) begin
            load_beat(src, $urandom, KW'($urandom_range(1, 15)), b == len - 1, (b == 0) ? first_gap : 0);
        end
    endtask

    function automatic logic next_mready(input int c);
        if (mr_random) return ($urandom_range(0, 9) < 7);
        return !(c >= stall_lo && c <= stall_hi);
    endfunction

    function automatic bit pending();
        bit p = ref_busy || (ref_buf.size() != 0);
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    // Behavioural model: arbitration by rule, the output buffer as a queue of at most two beats.
    task automatic model_check_update();
        logic [N-1:0] rdy;
        out_beat_t    nb;
        bit           pop, push, push_last, found;
        rdy = '0;
        if (ref_busy && ref_buf.size() < 2) rdy[ref_grant] = 1'b1;
        exp_ready = rdy;
        checkOutput($sformatf("s_tready c%0d", cyc), 64'(s_tready), 64'(rdy));
        checkOutput($sformatf("busy c%0d", cyc), 64'(busy), 64'(ref_busy));
        checkOutput($sformatf("m_tvalid c%0d", cyc), 64'(m_tvalid), 64'(ref_buf.size() > 0));
        if (ref_buf.size() > 0) begin
            checkOutput($sformatf("m_tdata c%0d", cyc), 64'(m_tdata), 64'(ref_buf[0].data));
            checkOutput($sformatf("m_tkeep c%0d", cyc), 64'(m_tkeep), 64'(ref_buf[0].keep));
            checkOutput($sformatf("m_tlast c%0d", cyc), 64'(m_tlast), 64'(ref_buf[0].last));
            checkOutput($sformatf("m_tid c%0d", cyc), 64'(m_tid), 64'(ref_buf[0].tid));
        end
        if (m_tvalid && m_tready) begin
            dut_data_log.push_back(m_tdata);
            if (m_tlast) dut_pkt_log.push_back(int'(m_tid));
        end
        if (bp_watch && cyc >= 4 && cyc <= 8 && !s_tready[2]) bp_obs++;
        pop       = (ref_buf.size() > 0) && m_tready;
        push      = ref_busy && s_tvalid[ref_grant] && rdy[ref_grant] && (src_q[ref_grant].size() > 0);
        push_last = push && src_q[ref_grant][0].last;
        if (pop) void'(ref_buf.pop_front());
        if (push) begin
            nb.data = src_q[ref_grant][0].data;
            nb.keep = src_q[ref_grant][0].keep;
            nb.last = src_q[ref_grant][0].last;
            nb.tid  = ref_grant;
            ref_buf.push_back(nb);
        end
        if (!ref_busy) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && s_tvalid[(ref_last + k) % N]) begin
                    ref_grant = (ref_last + k) % N;
                    found     = 1'b1;
                end
            end
            ref_busy = found;
        end else if (push_last) begin
            ref_last = ref_grant;
            ref_busy = 1'b0;
        end
    endtask

    task automatic source_advance();
        for (int i = 0; i < N; i++) begin
            if (presenting[i] && s_tvalid[i] && exp_ready[i]) begin
                void'(src_q[i].pop_front());
                presenting[i] = 1'b0;
                if (src_q[i].size() > 0) pause[i] = src_q[i][0].gap;
            end
            if (!presenting[i] && src_q[i].size() > 0) begin
                if (pause[i] > 0) pause[i]--;
                else presenting[i] = 1'b1;
            end
        end
    endtask

    task automatic step();
        logic mr;
        @(negedge aclk);
        model_check_update();
        source_advance();
        mr = next_mready(cyc + 1);
        @(posedge aclk);
        #1;
        applyStimulus(mr);
        cyc++;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        model_reset();
        applyStimulus(1'b1);
        repeat (2) @(posedge aclk);
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic start_scenario();
        for (int i = 0; i < N; i++) begin
            presenting[i] = 1'b0;
            pause[i]      = (src_q[i].size() > 0) ? src_q[i][0].gap : 0;
        end
        exp_ready = '0;
        dut_pkt_log.delete();
        dut_data_log.delete();
        exp_pkt.delete();
        exp_data.delete();
        cyc = 0;
        source_advance();
        applyStimulus(next_mready(0));
    endtask

    task automatic run_until_drained(input string name, input int max_cycles);
        int n = 0;
        while (pending() && n < max_cycles) begin
            step();
            n++;
        end
        checkOutput({name, " drained within cycle budget"}, 64'(pending()), 64'(0));
        repeat (2) step();
    endtask

    task automatic check_order(input string name);
        checkOutput({name, " packet count"}, 64'(dut_pkt_log.size()), 64'(exp_pkt.size()));
        for (int k = 0; k < exp_pkt.size() && k < dut_pkt_log.size(); k++)
            checkOutput($sformatf("%s packet %0d tid", name, k), 64'(dut_pkt_log[k]), 64'(exp_pkt[k]));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
        m_tready = 1'b0; aresetn = 1'b0;
        mr_random = 1'b0; stall_lo = 1; stall_hi = 0; bp_watch = 1'b0; bp_obs = 0;
        model_reset();
        #3;
        checkOutput("reset m_tvalid", 64'(m_tvalid), 64'(0));
        checkOutput("reset m_tdata", 64'(m_tdata), 64'(0));
        checkOutput("reset m_tkeep", 64'(m_tkeep), 64'(0));
        checkOutput("reset m_tlast", 64'(m_tlast), 64'(0));
        checkOutput("reset m_tid", 64'(m_tid), 64'(0));
        checkOutput("reset s_tready", 64'(s_tready), 64'(0));
        checkOutput("reset busy", 64'(busy), 64'(0));
        repeat (2) @(posedge aclk);
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Single source, three beats: {vld,data,last,mready | mvalid,mdata,mlast,ready0,busy}
        vec[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
        vec[1] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1};
        vec[2] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b1};
        vec[3] = '{1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b1};
        vec[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b0, 1'b0};
        vec[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
        for (int r = 0; r < 6; r++) begin
            s_tvalid = {3'b000, vec[r].vld};
            s_tdata[DW-1:0] = vec[r].data;
            s_tkeep[KW-1:0] = '1;
            s_tlast = {3'b000, vec[r].last};
            m_tready = vec[r].mready;
            @(negedge aclk);
            checkOutput($sformatf("vec%0d m_tvalid", r), 64'(m_tvalid), 64'(vec[r].exp_mvalid));
            checkOutput($sformatf("vec%0d busy", r), 64'(busy), 64'(vec[r].exp_busy));
            checkOutput($sformatf("vec%0d s_tready", r), 64'(s_tready), 64'({3'b000, vec[r].exp_ready0}));
            if (vec[r].exp_mvalid) begin
                checkOutput($sformatf("vec%0d m_tdata", r), 64'(m_tdata), 64'(vec[r].exp_mdata));
                checkOutput($sformatf("vec%0d m_tlast", r), 64'(m_tlast), 64'(vec[r].exp_mlast));
                checkOutput($sformatf("vec%0d m_tid", r), 64'(m_tid), 64'(0));
            end
            @(posedge aclk);
            #1;
        end

        // All four sources hold two 2-beat packets each.
        do_reset();
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 2; b++)
                    load_beat(i, 32'hC000_0000 | (i << 8) | (p << 4) | b, '1, b == 1, 0);
        mr_random = 1'b0; stall_lo = 1; stall_hi = 0;
        start_scenario();
        for (int k = 0; k < 8; k++) exp_pkt.push_back(k % 4);
        run_until_drained("four", 200);
        check_order("four");

        // Backpressure: src2 sends six beats while the sink stalls for cycles 3..8.
        do_reset();
        stall_lo = 3; stall_hi = 8;
        for (int b = 0; b < 6; b++) load_beat(2, 32'hB000_0000 + b, '1, b == 5, 0);
        start_scenario();
        for (int b = 0; b < 6; b++) exp_data.push_back(32'hB000_0000 + b);
        bp_watch = 1'b1; bp_obs = 0;
        run_until_drained("backpressure", 200);
        bp_watch = 1'b0;
        checkOutput("backpressure s_tready[2] low cycles", 64'(bp_obs), 64'(5));
        checkOutput("backpressure beat count", 64'(dut_data_log.size()), 64'(6));
        for (int b = 0; b < 6 && b < dut_data_log.size(); b++)
            checkOutput($sformatf("backpressure beat %0d", b), 64'(dut_data_log[b]), 64'(exp_data[b]));

        // Fairness: src1 streams single-beat packets, src3 arrives at cycle 5.
        do_reset();
        stall_lo = 1; stall_hi = 0;
        for (int p = 0; p < 8; p++) load_beat(1, 32'h1100_0000 + p, '1, 1'b1, 0);
        load_beat(3, 32'h3300_0000, '1, 1'b1, 5);
        start_scenario();
        for (int k = 0; k < 9; k++) exp_pkt.push_back((k == 3) ? 3 : 1);
        run_until_drained("fairness", 300);
        check_order("fairness");

        // Stalled source keeps its grant while src1 waits.
        do_reset();
        for (int b = 0; b < 4; b++) load_beat(0, 32'h0A00_0000 + b, '1, b == 3, (b == 1) ? 10 : 0);
        load_beat(1, 32'h1B00_0000, '1, 1'b0, 0);
        load_beat(1, 32'h1B00_0001, '1, 1'b1, 0);
        start_scenario();
        exp_pkt.push_back(0);
        exp_pkt.push_back(1);
        run_until_drained("stalled", 300);
        check_order("stalled");

        // Randomized traffic on all sources with random sink backpressure.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int i = 0; i < N; i++)
                for (int p = 0; p < int'($urandom_range(2, 5)); p++)
                    load_packet(i, $urandom_range(1, 4), $urandom_range(0, 4));
            mr_random = 1'b1;
            start_scenario();
            run_until_drained($sformatf("random%0d", round), 3000);
            checkOutput($sformatf("random%0d beat count", round), 64'(dut_data_log.size()), 64'(total_loaded));
        end
        mr_random = 1'b0;

        // Reset asserted asynchronously while src1's second beat is in flight.
        do_reset();
        for (int b = 0; b < 4; b++) load_beat(1, 32'hD000_0000 + b, '1, b == 3, 0);
        start_scenario();
        step();
        step();
        #2 aresetn = 1'b0;
        #1;
        checkOutput("async reset m_tvalid", 64'(m_tvalid), 64'(0));
        checkOutput("async reset m_tdata", 64'(m_tdata), 64'(0));
        checkOutput("async reset s_tready", 64'(s_tready), 64'(0));
        checkOutput("async reset busy", 64'(busy), 64'(0));
        model_reset();
        applyStimulus(1'b1);
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk);
        #1;
        load_beat(1, 32'hD100_0000, '1, 1'b1, 0);
        load_beat(0, 32'hE000_0000, '1, 1'b1, 0);
        start_scenario();
        exp_pkt.push_back(0);
        exp_pkt.push_back(1);
        run_until_drained("post-reset", 100);
        check_order("post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N-to-1 AXI4-Stream arbiter that shares one downstream stream (e.g. the slave VIP or a DMA sink) between N_SRC master streams.
- Round-robin selection at packet granularity. A grant is held from the first beat until the TLAST beat is accepted.
- The winning source index is reported on m_tid.
- The output is fully registered through a 2-entry skid buffer, so timing is isolated from the downstream sink.

Parameters:
- N_SRC, 4, number of upstream sources (2..16)
- DATA_W, 32, TDATA width in bits (multiple of 8)
- ID_W, $clog2(N_SRC) with minimum 1, width of m_tid

Ports:
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- s_tvalid  in  N_SRC  per-source TVALID
- s_tready  out  N_SRC  per-source TREADY
- s_tdata  in  N_SRC*DATA_W  per-source TDATA; source i occupies bits [i*DATA_W +: DATA_W]
- s_tkeep  in  N_SRC*DATA_W/8  per-source TKEEP, packed the same way
- s_tlast  in  N_SRC  per-source TLAST
- m_tvalid  out  1  output TVALID
- m_tready  in  1  output TREADY
- m_tdata  out  DATA_W  output TDATA
- m_tkeep  out  DATA_W/8  output TKEEP
- m_tlast  out  1  output TLAST
- m_tid  out  ID_W  index of the source that produced the beat
- busy  out  1  high while a grant is held (state BUSY)

Behaviour:
- Reset, asynchronous on aresetn low:
  - state=IDLE, grant=0, last_grant=N_SRC-1 (so source 0 has first priority)
  - skid buffer emptied; m_tvalid=0, m_tdata/m_tkeep/m_tlast/m_tid=0
  - s_tready=0, busy=0
- Reset mid-packet: the in-flight packet is abandoned. There is no flush and no synthetic TLAST. After release, arbitration restarts from source 0.
- FSM IDLE:
  - s_tready all 0.
  - If any s_tvalid is high, grant = first asserted source searching last_grant+1, last_grant+2, … modulo N_SRC. Go to BUSY on the next edge.
  - Otherwise stay in IDLE.
- FSM BUSY:
  - s_tready[grant] = skid buffer not full; every other s_tready is 0.
  - A source beat is accepted when s_tvalid[grant] && s_tready[grant]. It is written to the skid buffer with tid=grant.
  - On an accepted beat with s_tlast=1: last_grant<=grant, go to IDLE.
  - Otherwise stay in BUSY; the grant cannot be preempted.
- Arbitration decision is combinational on IDLE inputs and registered into grant. It must not depend on m_tready.
- Skid buffer:
  - 2 entries, FIFO order.
  - m_* outputs are driven from the head register.
  - "Not full" means fewer than 2 entries. Simultaneous push and pop keeps occupancy constant.
- Latency:
  - s_tvalid rising in IDLE at cycle 0 → grant registered at cycle 1 → first m_tvalid at cycle 2.
  - Streaming within a packet runs at 1 beat/cycle when m_tready=1.
  - Packet-to-packet gap is exactly one IDLE cycle at the source side.
- Backpressure: m_tready=0 fills the buffer after 2 beats, then s_tready[grant] drops. No beat is lost or duplicated.
- A source that deasserts s_tvalid mid-packet keeps the grant indefinitely. No timeout is required.
- m_tvalid, once high, stays high with stable payload until m_tready=1 (AXI4-Stream rule). The block relies on the same rule from its sources.
- N_SRC=1 degenerates to a registered pass-through with the one-cycle IDLE gap.

Decomposition:
- Shared package axis_arb_pkg:
  - beat struct typedef {tdata, tkeep, tlast, tid}
  - state enum {IDLE, BUSY}
  - function rr_pick(req, last) returning the next index
- Sub-module axis_skid_buf: 2-entry registered buffer for the beat struct, with valid/ready on both sides. It is reusable by other stream blocks.

Test Plan:
- Single source: src0 sends 3 beats 0xA0,0xA1,0xA2 (last on 3rd), m_tready=1 → m_tvalid first high at cycle 2. Data appears in order, m_tid=0, m_tlast on 3rd beat, busy low the cycle after acceptance.
- All 4 sources each hold a 2-beat packet from cycle 0 → packet order on m is tid 0,1,2,3, then 0 again. No beats interleave between packets; one gap cycle between packets.
- Backpressure: src2 sends 6 beats while m_tready is 0 for cycles 3–8 → exactly 2 beats buffered, s_tready[2]=0 during the stall. All 6 beats come out in order once m_tready=1.
- Fairness: src1 continuously offers 1-beat packets and src3 offers one packet at cycle 5 → src3 is served immediately after the current src1 packet, before src1's next packet.
- Stalled source: src0 drops s_tvalid after beat 1 of 4 for 10 cycles while src1 is valid → grant stays on 0, s_tready[1]=0 throughout. src1 is served only after src0's TLAST.
- Reset mid-packet: aresetn pulsed low during beat 2 of src1's packet → m_tvalid=0 and s_tready=0 asynchronously. After release, src0 (if valid) wins first.
